serial_mag_compare_ctrl: RTL

Bit-serial magnitude-compare controller that time-shares one cascadable 1-bit comparator slice (inputs a, b, e, l, g; outputs E, L, G) across a WIDTH-bit operand pair. On a start request it captures both operands and steps the slice MSB-first, one bit per clock, feeding each step's E/L/G back as the next step's e/l/g. When the walk finishes it reports a registered equal/less/greater result with a one-cycle done pulse. It sits between a requesting datapath and the shared comparator slice, replacing a WIDTH-slice ripple chain.

---
 rtl/serial_mag_compare_ctrl_if.sv | 31 +++
 rtl/serial_mag_compare_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/serial_mag_compare_ctrl_if.sv
// Request/result bundle between a requesting datapath and the bit-serial
// magnitude-compare controller.
//
// Handshake: start is a request that the controller accepts on any rising
// edge where busy is low; a_in/b_in are sampled only on that accepting edge.
// There is no ready back-pressure beyond busy. done is a one-cycle pulse that
// marks the edge on which eq/lt/gt were refreshed; eq/lt/gt then hold until
// the next completion.
interface serial_mag_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             eq;
    logic             lt;
    logic             gt;
    logic [1:0]       dbg_state;   // controller FSM state, for checkers

    modport master (
        output start, a_in, b_in,
        input  busy, done, eq, lt, gt, dbg_state
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, eq, lt, gt, dbg_state
    );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// Bit-serial magnitude-compare controller. One 1-bit cascadable comparator
// slice is walked MSB-first over a WIDTH-bit operand pair, one bit per clock,
// with each step's E/L/G fed back as the next step's e/l/g.
//
// Optional feature macro: SERIAL_CMP_EARLY_EXIT_EN. When defined, the walk
// stops on the first step that yields L=1 or G=1. Results are identical in
// both builds; only latency differs.
module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    serial_mag_compare_ctrl_if.slave   bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;       // shift left; MSB is the bit in use
    logic [IW-1:0]    idx_q;
    logic             e_q, l_q, g_q;  // cascade inputs of the next step
    logic             eq_q, lt_q, gt_q;

    logic             a_bit, b_bit;
    logic             e_s, l_s, g_s;  // slice outputs for the current step
    logic             early_hit;
    logic             last_step;
    logic             load_en;
    logic             step_en;

    // Shared comparator slice applied to the current bit pair.
    always_comb begin
        a_bit = a_q[WIDTH-1];
        b_bit = b_q[WIDTH-1];
        e_s   = e_q & ~(a_bit ^ b_bit);
        l_s   = l_q | (e_q & ~a_bit & b_bit);
        g_s   = g_q | (e_q & a_bit & ~b_bit);
    end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    // Once any bit differs the outcome is decided; lower bits cannot change it.
    assign early_hit = l_s | g_s;
`else
    assign early_hit = 1'b0;
`endif

    // Next-state and control strobes; a start is taken whenever not in RUN.
    always_comb begin
        state_d   = state_q;
        load_en   = 1'b0;
        step_en   = 1'b0;
        last_step = (idx_q == '0) | early_hit;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load_en = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_en = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load_en = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, operand shifters, cascade and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IW'(WIDTH - 1);
            e_q     <= 1'b1;
            l_q     <= 1'b0;
            g_q     <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_en) begin
                a_q   <= bus.a_in;
                b_q   <= bus.b_in;
                idx_q <= IW'(WIDTH - 1);
                e_q   <= 1'b1;
                l_q   <= 1'b0;
                g_q   <= 1'b0;
            end else if (step_en) begin
                a_q   <= a_q << 1;
                b_q   <= b_q << 1;
                idx_q <= idx_q - IW'(1);
                e_q   <= e_s;
                l_q   <= l_s;
                g_q   <= g_s;
                if (last_step) begin
                    eq_q <= e_s;
                    lt_q <= l_s;
                    gt_q <= g_s;
                end
            end
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.eq        = eq_q;
    assign bus.lt        = lt_q;
    assign bus.gt        = gt_q;
    assign bus.dbg_state = state_q;
endmodule
